vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the number of strobe cycles per SRAM access (legal range 1..7).
REQ-002 Parameter VID_PRIO, default 1, SHALL give video priority over CPU when both requests are new in the same cycle.
REQ-003 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 VAD  in  16  video fetch address.
REQ-006 vram_cs  in  1  video request, held high until completion is seen.
REQ-007 VDI  out  8  video read data, valid in the vram_complete cycle and held until the next video completion.
REQ-008 vram_complete  out  1  one-clock video completion pulse.
REQ-009 cpu_addr  in  16  CPU address.
REQ-010 cpu_di  in  8  CPU write data.
REQ-011 cpu_do  out  8  CPU read data, valid with cpu_ready and held until the next CPU completion.
REQ-012 cpu_rw  in  1  CPU direction: 1 = read, 0 = write.
REQ-013 cpu_cs  in  1  CPU request, held with stable address, data and rw until cpu_ready.
REQ-014 cpu_ready  out  1  one-clock CPU completion pulse.
REQ-015 ram_a  out  16  SRAM address.
REQ-016 ram_d_o  out  8  SRAM write data.
REQ-017 ram_d_i  in  8  SRAM read data.
REQ-018 ram_cs_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.

Function
REQ-019 The FSM SHALL have the states IDLE, SETUP, STROBE and DONE, with a registered owner flag (VID or CPU).
REQ-020 In IDLE, an eligible request SHALL latch its address, write data, rw and owner, then move to SETUP; a video request is always a read.
REQ-021 In SETUP, ram_cs_n SHALL be 0 and ram_oe_n and ram_we_n SHALL be 1 for exactly one clock, with ram_a driven.
REQ-022 STROBE SHALL last WAIT_CYCLES clocks, using a 3-bit down-counter.
  - Read: ram_oe_n = 0.
  - Write: ram_we_n = 0 in every STROBE clock except the last, where it is 1 so data holds.
  - ram_a and ram_d_o SHALL stay stable throughout.
REQ-023 On the final STROBE edge, a read SHALL capture ram_d_i into VDI or cpu_do according to the owner.
REQ-024 DONE SHALL last one clock, pulse the owner's completion output, release ram_cs_n to 1, and return to IDLE.
REQ-025 Latency from request sampled in IDLE to the completion pulse SHALL be WAIT_CYCLES+2 clocks (4 at default).
REQ-026 Eligibility rule: after a completion, that requester is ineligible until its cs has been observed low for at least one clock, so a request still held during the DONE edge is never served twice.
REQ-027 Arbitration: when both requests are eligible, the requester not served last SHALL win; on a cold start, the winner follows VID_PRIO.
REQ-028 A request that arrives during an access SHALL wait; it is never dropped.
REQ-029 If cs drops mid-access, the access SHALL complete, the completion SHALL still pulse, and the result SHALL be ignored.
REQ-030 Only one SRAM access SHALL be in flight; no completion pulse is ever produced outside DONE.

Reset
REQ-031 While rst = 0, the FSM SHALL be in IDLE, and all outputs SHALL hold these values:
  - ram_cs_n, ram_oe_n, ram_we_n = 1.
  - ram_a = 0000, ram_d_o = 00.
  - VDI = 00, cpu_do = 00.
  - vram_complete = 0, cpu_ready = 0.
  - Both eligibility flags set; last-owner = CPU.
REQ-032 Reset asserted mid-access SHALL abort the access immediately, deassert all strobes, and produce no completion pulse.

Structure
REQ-033 A shared package vram_pkg SHALL hold the state enum, the owner encoding, and the WAIT_CYCLES default.
REQ-034 The block is a single module with no sub-module; the strobe counter and FSM are inline.

Verification
REQ-035 Video read: SRAM[0x1234] = A5, vram_cs = 1 with VAD = 1234 -> ram_oe_n low for 2 clocks, vram_complete pulses 4 clocks later, and VDI = A5.
REQ-036 CPU write: cpu_cs = 1, rw = 0, addr = 8000, di = 3C -> ram_we_n low for 1 clock, cpu_ready pulses after 4 clocks, and a read of 8000 returns 3C.
REQ-037 Simultaneous requests after reset -> video is served first, then CPU; a repeated tie alternates the winner.
REQ-038 vram_cs held high 2 clocks past vram_complete -> exactly one SRAM access occurs.
REQ-039 rst = 0 in the first STROBE clock of a CPU write -> ram_we_n = 1 at once, and no cpu_ready pulse occurs.
REQ-040 WAIT_CYCLES = 1, back-to-back video requests -> completions are spaced 3 clocks apart plus the cs-low gap, with no overlapping strobes.

Source files
------------

// File: rtl/vram_pkg.sv
// vram_pkg: shared FSM state, owner encoding and default strobe length for vram_arbiter.
package vram_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
    typedef enum logic {OWN_VID, OWN_CPU} owner_t;
    localparam int WAIT_DEFAULT = 2;
endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one asynchronous SRAM between a video fetch port and a CPU port.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_DEFAULT,
    parameter bit VID_PRIO    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] VAD,
    input  logic        vram_cs,
    output logic [7:0]  VDI,
    output logic        vram_complete,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    input  logic        cpu_rw,
    input  logic        cpu_cs,
    output logic        cpu_ready,
    output logic [15:0] ram_a,
    output logic [7:0]  ram_d_o,
    input  logic [7:0]  ram_d_i,
    output logic        ram_cs_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);
    state_t      state, next;
    owner_t      owner, last_own;
    logic        cold, vid_ok, cpu_ok, rd;
    logic [2:0]  cnt;
    logic [15:0] addr;
    logic [7:0]  wd, vdi_r, cdo_r;
    logic        vreq, creq, go, pick_cpu, last_s, done_vid, done_cpu;

    assign vreq     = vram_cs && vid_ok;
    assign creq     = cpu_cs && cpu_ok;
    assign go       = vreq || creq;
    // On a tie the requester not served last wins; before any service VID_PRIO decides.
    assign pick_cpu = creq && (!vreq || (cold ? !VID_PRIO : last_own == OWN_VID));
    assign last_s   = cnt == 3'd1;
    assign done_vid = state == DONE && owner == OWN_VID;
    assign done_cpu = state == DONE && owner == OWN_CPU;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= next;

    always_comb begin
        next = state == IDLE   ? (go ? SETUP : IDLE) :
               state == SETUP  ? STROBE :
               state == STROBE ? (last_s ? DONE : STROBE) : IDLE;
    end

    always_comb begin
        ram_cs_n      = !(state == SETUP || state == STROBE);
        ram_oe_n      = !(state == STROBE && rd);
        // The final write strobe clock keeps we_n high so data holds past the write edge.
        ram_we_n      = !(state == STROBE && !rd && !last_s);
        vram_complete = done_vid;
        cpu_ready     = done_cpu;
        ram_a         = addr;
        ram_d_o       = wd;
        VDI           = vdi_r;
        cpu_do        = cdo_r;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= OWN_VID;
            last_own <= OWN_CPU;
            cold     <= 1'b1;
            vid_ok   <= 1'b1;
            cpu_ok   <= 1'b1;
            rd       <= 1'b1;
            cnt      <= '0;
            addr     <= '0;
            wd       <= '0;
            vdi_r    <= '0;
            cdo_r    <= '0;
        end else begin
            if (state == IDLE && go) begin
                owner    <= pick_cpu ? OWN_CPU : OWN_VID;
                last_own <= pick_cpu ? OWN_CPU : OWN_VID;
                cold     <= 1'b0;
                addr     <= pick_cpu ? cpu_addr : VAD;
                rd       <= pick_cpu ? cpu_rw : 1'b1;
                if (pick_cpu) wd <= cpu_di;
            end
            cnt <= state == SETUP ? 3'(WAIT_CYCLES) : state == STROBE ? cnt - 3'd1 : cnt;
            if (state == STROBE && last_s && rd && owner == OWN_VID) vdi_r <= ram_d_i;
            if (state == STROBE && last_s && rd && owner == OWN_CPU) cdo_r <= ram_d_i;
            // A request still held across its own DONE edge stays blocked until cs is seen low.
            vid_ok <= done_vid ? !vram_cs : (vid_ok || !vram_cs);
            cpu_ok <= done_cpu ? !cpu_cs : (cpu_ok || !cpu_cs);
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a phase-counting access model.
module tb_vram_arbiter;
    localparam int W  = 2;
    localparam bit VP = 1'b1;

    logic        clk = 0, rst = 1;
    logic [15:0] vad = 0, caddr = 0, ra, r2a, v2ad = 0;
    logic        vcs = 0, ccs = 0, crw = 1, v2cs = 0;
    logic [7:0]  cdi = 0, vdi, cdo, rdo, rdi, v2di, r2do, c2do, r2di;
    logic        vcomp, crdy, rcs, roe, rwe, v2comp, c2rdy, r2cs, r2oe, r2we;
    logic [7:0]  mem  [0:65535];
    logic [7:0]  mmem [0:65535];
    int checks = 0, failures = 0;
    bit started = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.WAIT_CYCLES(W), .VID_PRIO(VP)) dut (
        .clk(clk), .rst(rst), .VAD(vad), .vram_cs(vcs), .VDI(vdi), .vram_complete(vcomp),
        .cpu_addr(caddr), .cpu_di(cdi), .cpu_do(cdo), .cpu_rw(crw), .cpu_cs(ccs), .cpu_ready(crdy),
        .ram_a(ra), .ram_d_o(rdo), .ram_d_i(rdi), .ram_cs_n(rcs), .ram_oe_n(roe), .ram_we_n(rwe));

    vram_arbiter #(.WAIT_CYCLES(1), .VID_PRIO(1'b0)) dut1 (
        .clk(clk), .rst(rst), .VAD(v2ad), .vram_cs(v2cs), .VDI(v2di), .vram_complete(v2comp),
        .cpu_addr(16'h0), .cpu_di(8'h0), .cpu_do(c2do), .cpu_rw(1'b1), .cpu_cs(1'b0), .cpu_ready(c2rdy),
        .ram_a(r2a), .ram_d_o(r2do), .ram_d_i(r2di), .ram_cs_n(r2cs), .ram_oe_n(r2oe), .ram_we_n(r2we));

    assign rdi  = mem[ra];
    assign r2di = mem[r2a];
    always @(posedge clk) if (!rcs && !rwe) mem[ra] <= rdo;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, a, e, $time);
        end
    endtask

    // Model: ph counts clocks since the IDLE cycle that accepted the access (-1 = idle).
    int ph = -1;
    bit m_own = 0, m_rd = 1, vok = 1, cok = 1, cold = 1, last = 1, mv, mc, mw;
    logic [15:0] m_a = 0;
    logic [7:0]  m_wd = 0, m_vdi = 0, m_cdo = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = -1; m_a = 0; m_wd = 0; m_vdi = 0; m_cdo = 0;
            vok = 1; cok = 1; cold = 1; last = 1; m_rd = 1; m_own = 0;
        end else begin
            mv = vcs && vok;
            mc = ccs && cok;
            if (ph >= 2 && ph <= W && !m_rd) mmem[m_a] = m_wd;
            if (ph == W + 1 && m_rd && m_own) m_cdo = mmem[m_a];
            if (ph == W + 1 && m_rd && !m_own) m_vdi = mmem[m_a];
            vok = (ph == W + 2 && !m_own) ? !vcs : (vok || !vcs);
            cok = (ph == W + 2 && m_own) ? !ccs : (cok || !ccs);
            if (ph == W + 2) ph = -1;
            else if (ph >= 1) ph++;
            else if (mv || mc) begin
                mw = mc && (!mv || (cold ? !VP : !last));
                m_own = mw; last = mw; cold = 0;
                m_rd = mw ? crw : 1'b1;
                m_a = mw ? caddr : vad;
                if (mw) m_wd = cdi;
                ph = 1;
            end
        end
    end

    always @(negedge clk) if (started) begin
        chk("vram_complete", vcomp, ph == W + 2 && !m_own);
        chk("cpu_ready", crdy, ph == W + 2 && m_own);
        chk("ram_cs_n", rcs, !(ph >= 1 && ph <= W + 1));
        chk("ram_oe_n", roe, !(ph >= 2 && ph <= W + 1 && m_rd));
        chk("ram_we_n", rwe, !(ph >= 2 && ph <= W && !m_rd));
        chk("ram_a", ra, m_a);
        chk("VDI", vdi, m_vdi);
        chk("cpu_do", cdo, m_cdo);
        if (!m_rd && ph >= 1 && ph <= W + 1) chk("ram_d_o", rdo, m_wd);
    end

    task automatic access(input bit isv, input bit rw, input logic [15:0] a, input logic [7:0] d,
                          input int hold, output int lat, output int oe_c, output int we_c, output int cs_c);
        @(posedge clk); #2;
        if (isv) begin vcs = 1; vad = a; end
        else begin ccs = 1; crw = rw; caddr = a; cdi = d; end
        lat = -1; oe_c = 0; we_c = 0; cs_c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            oe_c += int'(!roe); we_c += int'(!rwe); cs_c += int'(!rcs);
            if (isv ? vcomp : crdy) begin lat = i; break; end
        end
        repeat (hold) begin
            @(posedge clk); #2;
            @(negedge clk);
            cs_c += int'(!rcs);
        end
        @(posedge clk); #2;
        if (isv) vcs = 0; else ccs = 0;
    endtask

    task automatic tie(output int vl, output int cl);
        bit dv, dc;
        @(posedge clk); #2;
        vcs = 1; vad = 16'h1234; ccs = 1; crw = 1; caddr = 16'h8000;
        vl = -1; cl = -1; dv = 0; dc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (vcomp) begin vl = i; dv = 1; end
            if (crdy) begin cl = i; dc = 1; end
            @(posedge clk); #2;
            if (dv) vcs = 0;
            if (dc) ccs = 0;
            if (dv && dc) break;
        end
        vcs = 0; ccs = 0;
    endtask

    int lat, oe_c, we_c, cs_c, vl, cl, nrdy;
    bit vseen, cseen;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            mmem[i] = mem[i];
        end
        mem[16'h1234] = 8'hA5; mmem[16'h1234] = 8'hA5;
        #1 rst = 0;
        #1;
        chk("rst_cs_n", rcs, 1); chk("rst_oe_n", roe, 1); chk("rst_we_n", rwe, 1);
        chk("rst_ram_a", ra, 0); chk("rst_ram_d_o", rdo, 0); chk("rst_VDI", vdi, 0);
        chk("rst_cpu_do", cdo, 0); chk("rst_complete", vcomp, 0); chk("rst_ready", crdy, 0);
        started = 1;
        @(posedge clk); #2 rst = 1;

        tie(vl, cl);
        chk("tie1_vid_lat", vl, 4); chk("tie1_cpu_lat", cl, 9);

        access(1, 1, 16'h1234, 8'h00, 0, lat, oe_c, we_c, cs_c);
        chk("vrd_lat", lat, 4); chk("vrd_oe_clocks", oe_c, 2); chk("vrd_VDI", vdi, 8'hA5);

        tie(vl, cl);
        chk("tie2_cpu_lat", cl, 4); chk("tie2_vid_lat", vl, 9);

        access(0, 0, 16'h8000, 8'h3C, 0, lat, oe_c, we_c, cs_c);
        chk("cwr_lat", lat, 4); chk("cwr_we_clocks", we_c, 1); chk("cwr_oe_clocks", oe_c, 0);
        access(0, 1, 16'h8000, 8'h00, 0, lat, oe_c, we_c, cs_c);
        chk("crd_lat", lat, 4); chk("crd_cpu_do", cdo, 8'h3C);

        access(1, 1, 16'h1234, 8'h00, 2, lat, oe_c, we_c, cs_c);
        chk("hold_lat", lat, 4); chk("hold_cs_clocks", cs_c, 3);

        @(posedge clk); #2;
        ccs = 1; crw = 0; caddr = 16'h8001; cdi = 8'h5A;
        @(posedge clk);
        @(posedge clk); #1;
        chk("abort_we_before", rwe, 0);
        #1 rst = 0;
        #1;
        chk("abort_we_n", rwe, 1); chk("abort_cs_n", rcs, 1); chk("abort_ready", crdy, 0);
        @(posedge clk); #2;
        ccs = 0; rst = 1;
        nrdy = 0;
        repeat (8) begin @(negedge clk); nrdy += int'(crdy); end
        chk("abort_no_ready", nrdy, 0);

        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            v2cs = 1; v2ad = 16'h1234 + 16'(k);
            lat = -1; oe_c = 0; cs_c = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                oe_c += int'(!r2oe); cs_c += int'(!r2cs);
                if (v2comp) begin lat = i; break; end
            end
            chk("w1_lat", lat, 3); chk("w1_oe_clocks", oe_c, 1); chk("w1_cs_clocks", cs_c, 2);
            chk("w1_VDI", v2di, mmem[16'h1234 + 16'(k)]);
            @(posedge clk); #2;
            v2cs = 0;
        end

        vseen = 0; cseen = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            vseen |= vcomp; cseen |= crdy;
            @(posedge clk); #2;
            if (!rst) rst = 1;
            else if ($urandom_range(0, 399) == 0) rst = 0;
            if (vcs) begin
                if ((vseen && $urandom_range(0, 1) == 0) || $urandom_range(0, 49) == 0) begin
                    vcs = 0; vseen = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                vcs = 1; vad = 16'h4000 + 16'($urandom_range(0, 15)); vseen = 0;
            end
            if (ccs) begin
                if ((cseen && $urandom_range(0, 1) == 0) || $urandom_range(0, 49) == 0) begin
                    ccs = 0; cseen = 0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                ccs = 1; crw = 1'($urandom); caddr = 16'h4000 + 16'($urandom_range(0, 15));
                cdi = 8'($urandom); cseen = 0;
            end
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
